// File: rtl/qddc_decim_v2.sv
// qddc_decim_v2: CIC decimation back-end of the quadrature DDC.
// Trim/gain/saturate, shared-FIR I/Q mux/demux and an output FIFO.
module qddc_decim_v2 #(
   parameter int ISZ        = 16,
   parameter int OSZ        = 16,
   parameter int N          = 5,
   parameter int MAXLOG2    = 5,
   parameter int DLW        = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic signed [ISZ-1:0] in_i,
   input  logic signed [ISZ-1:0] in_q,
   input  logic [DLW-1:0]        dec_log2,
   input  logic [1:0]            gain,
   output logic                  fir_out_valid,
   output logic signed [OSZ-1:0] fir_out_data,
   input  logic                  fir_in_valid,
   input  logic signed [OSZ-1:0] fir_in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [OSZ-1:0] out_i,
   output logic signed [OSZ-1:0] out_q,
   output logic                  sat_flag,
   output logic                  ovf_flag,
   input  logic                  clear_flags
);
   localparam int W   = ISZ + N * MAXLOG2;
   localparam int XW  = W + 5;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int WUW = $clog2(N + 1);
   localparam logic signed [XW-1:0] OMAX = {{(XW-OSZ+1){1'b0}}, {(OSZ-1){1'b1}}};
   localparam logic signed [XW-1:0] OMIN = {{(XW-OSZ+1){1'b1}}, {(OSZ-1){1'b0}}};

   logic [DLW-1:0]      d_eff, d_reg;
   logic                resync;
   logic signed [W-1:0] acc_i [N];
   logic signed [W-1:0] acc_q [N];
   logic signed [W-1:0] dly_i [N];
   logic signed [W-1:0] dly_q [N];
   logic signed [W-1:0] cmb_i [N];
   logic signed [W-1:0] cmb_q [N];
   logic [N-1:0]        cmb_v;
   logic signed [W-1:0] cap_i, cap_q;
   logic                cap_v;
   logic [MAXLOG2-1:0]  cnt;
   logic                cnt_last;
   logic [WUW-1:0]      wu;
   logic                warm;
   int                  sh;
   logic [OSZ:0]        tr_i, tr_q;
   logic                sat_evt;
   logic                tr_v, mux_q;
   logic signed [OSZ-1:0] tr_di, tr_dq;
   logic                par;
   logic signed [OSZ-1:0] i_hold;
   logic signed [OSZ-1:0] mem_i [FIFO_DEPTH];
   logic signed [OSZ-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]         wp, rp;
   logic                full, empty, pop, push, wr;

   // round, shift and clip one CIC result; MSB of the result flags clipping
   function automatic logic [OSZ:0] trim(logic signed [W-1:0] v, int s);
      logic signed [XW-1:0] x;
      logic signed [XW-1:0] one;
      x   = XW'(v);
      one = XW'(1);
      if (s > 0) x = (x + (one <<< (s - 1))) >>> s;
      else       x = x <<< (-s);
      if (x > OMAX) return {1'b1, OMAX[OSZ-1:0]};
      if (x < OMIN) return {1'b1, OMIN[OSZ-1:0]};
      return {1'b0, x[OSZ-1:0]};
   endfunction

   // clamp the requested ratio into the supported range
   always_comb begin
      d_eff = dec_log2;
      if (dec_log2 == '0) d_eff = DLW'(1);
      else if (int'(dec_log2) > MAXLOG2) d_eff = DLW'(MAXLOG2);
   end

   assign resync   = (d_eff != d_reg);
   assign cnt_last = (int'(cnt) == (1 << d_reg) - 1);
   assign warm     = (int'(wu) == N);
   assign sh       = ISZ + N * int'(d_reg) - OSZ - int'(gain);
   assign tr_i     = trim(cmb_i[N-1], sh);
   assign tr_q     = trim(cmb_q[N-1], sh);
   assign sat_evt  = cmb_v[N-1] && warm && !resync && (tr_i[OSZ] || tr_q[OSZ]);

   // track the effective ratio so a change can be detected one edge later
   always_ff @(posedge clk) begin
      d_reg <= d_eff;
   end

   // integrators, decimation counter, capture and comb chain
   always_ff @(posedge clk) begin
      if (reset || resync) begin
         for (int k = 0; k < N; k++) begin
            acc_i[k] <= '0;
            acc_q[k] <= '0;
            dly_i[k] <= '0;
            dly_q[k] <= '0;
            cmb_i[k] <= '0;
            cmb_q[k] <= '0;
         end
         cnt   <= '0;
         cap_v <= 1'b0;
         cap_i <= '0;
         cap_q <= '0;
         cmb_v <= '0;
      end else begin
         if (in_valid) begin
            acc_i[0] <= acc_i[0] + W'(in_i);
            acc_q[0] <= acc_q[0] + W'(in_q);
            for (int k = 1; k < N; k++) begin
               acc_i[k] <= acc_i[k] + acc_i[k-1];
               acc_q[k] <= acc_q[k] + acc_q[k-1];
            end
            cnt <= cnt_last ? '0 : cnt + 1'b1;
         end
         cap_v <= in_valid && cnt_last;
         if (in_valid && cnt_last) begin
            cap_i <= acc_i[N-1];
            cap_q <= acc_q[N-1];
         end
         cmb_v <= {cmb_v[N-2:0], cap_v};
         if (cap_v) begin
            cmb_i[0] <= cap_i - dly_i[0];
            cmb_q[0] <= cap_q - dly_q[0];
            dly_i[0] <= cap_i;
            dly_q[0] <= cap_q;
         end
         for (int k = 1; k < N; k++) begin
            if (cmb_v[k-1]) begin
               cmb_i[k] <= cmb_i[k-1] - dly_i[k];
               cmb_q[k] <= cmb_q[k-1] - dly_q[k];
               dly_i[k] <= cmb_i[k-1];
               dly_q[k] <= cmb_q[k-1];
            end
         end
      end
   end

   // warm-up discard, registered trim and I-then-Q mux toward the FIR
   always_ff @(posedge clk) begin
      if (reset || resync) begin
         wu            <= '0;
         tr_v          <= 1'b0;
         mux_q         <= 1'b0;
         fir_out_valid <= 1'b0;
         if (reset) begin
            tr_di        <= '0;
            tr_dq        <= '0;
            fir_out_data <= '0;
         end
      end else begin
         if (cmb_v[N-1] && !warm) wu <= wu + 1'b1;
         tr_v <= cmb_v[N-1] && warm;
         if (cmb_v[N-1] && warm) begin
            tr_di <= tr_i[OSZ-1:0];
            tr_dq <= tr_q[OSZ-1:0];
         end
         fir_out_valid <= tr_v || mux_q;
         mux_q         <= tr_v;
         if (tr_v) fir_out_data <= tr_di;
         else if (mux_q) fir_out_data <= tr_dq;
      end
   end

   // FIR return parity: even word is I, odd word completes the pair
   always_ff @(posedge clk) begin
      if (reset) begin
         par    <= 1'b0;
         i_hold <= '0;
      end else if (resync) begin
         par <= 1'b0;
      end else if (fir_in_valid) begin
         par <= !par;
         if (!par) i_hold <= fir_in_data;
      end
   end

   assign empty     = (wp == rp);
   assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign out_valid = !empty;
   assign out_i     = mem_i[rp[AW-1:0]];
   assign out_q     = mem_q[rp[AW-1:0]];
   assign pop       = out_valid && out_ready;
   assign push      = fir_in_valid && par;
   assign wr        = push && (!full || pop);

   // output FIFO; a pop frees room for a same-cycle write
   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem_i[k] <= '0;
            mem_q[k] <= '0;
         end
      end else begin
         if (wr) begin
            mem_i[wp[AW-1:0]] <= i_hold;
            mem_q[wp[AW-1:0]] <= fir_in_data;
            wp <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
      end
   end

   // sticky flags; a set event beats a same-cycle clear
   always_ff @(posedge clk) begin
      if (reset) begin
         sat_flag <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         sat_flag <= (sat_flag && !clear_flags) || sat_evt;
         ovf_flag <= (ovf_flag && !clear_flags) || (push && full && !pop);
      end
   end

endmodule

// File: tb/tb_qddc_decim_v2.sv
// tb_qddc_decim_v2: scoreboard bench for qddc_decim_v2 with FIR loopback.
// Expected pairs and strobe times come from a small CIC timing model.
module tb_qddc_decim_v2;
   localparam int ISZ = 16, OSZ = 16, N = 5, MAXLOG2 = 5, DLW = 3, FD = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic in_valid = 1'b0;
   logic signed [ISZ-1:0] in_i = '0, in_q = '0;
   logic [DLW-1:0] dec_log2 = 3'd2;
   logic [1:0] gain = 2'd0;
   logic fir_out_valid;
   logic signed [OSZ-1:0] fir_out_data;
   logic fir_in_valid = 1'b0;
   logic signed [OSZ-1:0] fir_in_data = '0;
   logic out_valid;
   logic out_ready = 1'b1;
   logic signed [OSZ-1:0] out_i, out_q;
   logic sat_flag, ovf_flag;
   logic clear_flags = 1'b0;

   typedef struct { bit chk; int i; int q; } pair_t;
   pair_t sb[$];
   int lat_q[$];

   int n_chk = 0, n_fail = 0, n_pop = 0, cyc = 0;
   int mcnt, mres, same, prod, d_m, cur_i, cur_q, t_i;
   bit limit = 1'b0, fq_phase = 1'b0;

   qddc_decim_v2 #(.ISZ(ISZ), .OSZ(OSZ), .N(N), .MAXLOG2(MAXLOG2),
                   .DLW(DLW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
      .dec_log2(dec_log2), .gain(gain),
      .fir_out_valid(fir_out_valid), .fir_out_data(fir_out_data),
      .fir_in_valid(fir_in_valid), .fir_in_data(fir_in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
      .sat_flag(sat_flag), .ovf_flag(ovf_flag), .clear_flags(clear_flags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      fir_in_valid <= fir_out_valid;
      fir_in_data <= fir_out_data;
   end

   task automatic check(string tag, logic signed [63:0] got, logic signed [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int deff(int v);
      if (v == 0) return 1;
      if (v > MAXLOG2) return MAXLOG2;
      return v;
   endfunction

   function automatic int expv(int x, int g);
      int v;
      v = x * (1 << g);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic step(bit v);
      int r;
      pair_t p;
      @(posedge clk);
      #1;
      in_valid = v;
      in_i = 16'(cur_i);
      in_q = 16'(cur_q);
      if (v) begin
         r = 1 << d_m;
         same++;
         mcnt++;
         if (mcnt == r) begin
            mcnt = 0;
            mres++;
            if (mres > N) begin
               lat_q.push_back(cyc + 1);
               p.chk = (same >= N * r + 1);
               p.i = expv(cur_i, int'(gain));
               p.q = expv(cur_q, int'(gain));
               if (!(limit && prod >= FD)) sb.push_back(p);
               prod++;
            end
         end
      end
   endtask

   task automatic run(int n, bit half);
      for (int k = 0; k < n; k++) begin
         step(1'b1);
         if (half) step(1'b0);
      end
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) step(1'b0);
   endtask

   task automatic model_clear();
      mcnt = 0; mres = 0; same = 0; prod = 0;
      sb.delete();
      lat_q.delete();
      fq_phase = 1'b0;
      d_m = deff(int'(dec_log2));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      clear_flags = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      idle(2);
   endtask

   task automatic set_d(int v);
      @(posedge clk); #1;
      in_valid = 1'b0;
      dec_log2 = DLW'(v);
      if (deff(v) != d_m) begin
         d_m = deff(v);
         mcnt = 0; mres = 0; same = 0;
      end
   endtask

   task automatic chk_zero(string tag);
      check({tag, "_ov"}, out_valid, 0);
      check({tag, "_oi"}, out_i, 0);
      check({tag, "_oq"}, out_q, 0);
      check({tag, "_fv"}, fir_out_valid, 0);
      check({tag, "_fd"}, fir_out_data, 0);
      check({tag, "_sat"}, sat_flag, 0);
      check({tag, "_ovf"}, ovf_flag, 0);
   endtask

   // latency of FIR words against strobe edges; FIFO pops against scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (fir_out_valid) begin
            if (!fq_phase) begin
               if (lat_q.size() == 0) check("fir_unexp", lat_q.size(), 1);
               else begin
                  t_i = lat_q.pop_front();
                  check("lat_i", cyc - t_i, N + 2);
               end
               fq_phase = 1'b1;
            end else begin
               check("lat_q", cyc - t_i, N + 3);
               fq_phase = 1'b0;
            end
         end
         if (out_valid && out_ready) begin
            n_pop++;
            if (sb.size() == 0) check("sb_empty", sb.size(), 1);
            else begin
               pair_t p;
               p = sb.pop_front();
               if (p.chk) begin
                  check("out_i", out_i, p.i);
                  check("out_q", out_q, p.q);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      bit seen;
      d_m = 2;
      cur_i = 1000; cur_q = -500;

      // reset values
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk_zero("rst");
      do_reset();

      // DC at R=4
      p0 = n_pop;
      run(80, 1'b0);
      idle(30);
      check("dc_sat", sat_flag, 0);
      check("dc_sb", sb.size(), 0);
      check("dc_lat", lat_q.size(), 0);
      check("dc_pops", n_pop - p0, prod);

      // saturation, then clear with a settled in-range input
      gain = 2'd1;
      cur_i = 20000;
      do_reset();
      run(60, 1'b0);
      cur_i = 1000; same = 0;
      run(60, 1'b0);
      idle(30);
      check("sat_set", sat_flag, 1);
      @(posedge clk); #1;
      clear_flags = 1'b1;
      @(posedge clk); #1;
      clear_flags = 1'b0;
      @(negedge clk);
      check("sat_clr", sat_flag, 0);
      run(40, 1'b0);
      idle(30);
      check("sat_stay", sat_flag, 0);
      check("sat_sb", sb.size(), 0);

      // overflow: 5 pairs into a 4-deep FIFO with consumer stalled
      gain = 2'd0;
      out_ready = 1'b0;
      do_reset();
      limit = 1'b1;
      p0 = n_pop;
      run(40, 1'b0);
      idle(30);
      check("ovf_set", ovf_flag, 1);
      check("ovf_ov", out_valid, 1);
      check("ovf_held", sb.size(), 4);
      @(posedge clk); #1;
      out_ready = 1'b1;
      idle(10);
      check("ovf_drain", n_pop - p0, 4);
      check("ovf_ov0", out_valid, 0);
      check("ovf_sticky", ovf_flag, 1);
      limit = 1'b0;

      // ratio change 2 -> 3 with FIFO contents preserved
      out_ready = 1'b0;
      do_reset();
      p0 = n_pop;
      run(28, 1'b0);
      idle(30);
      set_d(3);
      cur_q = -600; same = 0;
      run(56, 1'b0);
      idle(40);
      check("rs_held", sb.size(), 4);
      check("rs_ovf", ovf_flag, 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      idle(10);
      check("rs_drain", n_pop - p0, 4);
      check("rs_sb", sb.size(), 0);

      // dec_log2=0 behaves as R=2, half-rate input
      dec_log2 = 3'd0;
      cur_q = -500;
      do_reset();
      p0 = n_pop;
      run(18, 1'b1);
      idle(20);
      check("d0_pops", n_pop - p0, 4);
      check("d0_sb", sb.size(), 0);

      // reset just after the I word goes out
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step(1'b1);
         seen = fir_out_valid;
      end
      check("fir_wait", seen, 1);
      reset = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk_zero("midrst");
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      idle(2);
      p0 = n_pop;
      run(40, 1'b0);
      idle(30);
      check("post_pops", n_pop - p0, prod);
      check("post_sb", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/qddc_decim_v2.md
Name: qddc_decim_v2

Overview:
Parametrised decimation back-end of the quadrature DDC. It takes tuned I/Q samples with a valid strobe and performs N-stage CIC decimation at a runtime-selectable ratio R=2^dec_log2, followed by rounding, gain and saturation. I then Q are time-multiplexed into the shared external FIR decimator, and the FIR return stream is demultiplexed into an output FIFO with a valid/ready handshake. Overflow and saturation are reported through sticky status flags.

Parameters:
ISZ, 16, input word size (signed)
OSZ, 16, output/FIR word size (signed); OSZ <= ISZ+N required
N, 5, CIC stage count
MAXLOG2, 5, maximum dec_log2
DLW, 3, width of dec_log2 (>= clog2(MAXLOG2+1))
FIFO_DEPTH, 4, output FIFO depth in I/Q pairs (power of 2, >= 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  in_i/in_q valid this cycle
in_i  in  ISZ  tuned in-phase sample
in_q  in  ISZ  tuned quadrature sample
dec_log2  in  DLW  CIC ratio log2, R=2^dec_log2
gain  in  2  post-CIC left shift 0..3
fir_out_valid  out  1  word to FIR valid
fir_out_data  out  OSZ  word to FIR (I then Q)
fir_in_valid  in  1  FIR result valid
fir_in_data  in  OSZ  FIR result (I then Q)
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts
out_i  out  OSZ  FIFO head I
out_q  out  OSZ  FIFO head Q
sat_flag  out  1  sticky: saturation occurred
ovf_flag  out  1  sticky: FIFO full, pair dropped
clear_flags  in  1  clear sticky flags

Behaviour:
- Reset: all integrators, combs, counters, FIFO and parity cleared; out_valid=0, out_i=out_q=0, fir_out_valid=0, fir_out_data=0, sat_flag=ovf_flag=0.
- dec_log2 effective value d: 0 -> 1; >MAXLOG2 -> MAXLOG2.
- Resync: any change of effective d (registered compare) clears the CIC state, decimation counter, warm-up counter, mux and FIR parity on the next edge. FIFO contents and flags are kept.
- CIC: integrator width W=ISZ+N*MAXLOG2, two's-complement wrap. Integrators advance only on in_valid. A decimation counter counts accepted samples. The sample completing a group of R raises strobe, and the last-integrator value is captured.
- Combs: N registered stages with delay 1, each stage one cycle. The CIC result is valid N cycles after the strobe edge.
- Warm-up: the first N CIC results after reset or resync are discarded.
- Trim: shift s = ISZ+N*d-OSZ-gain. If s > 0: add 2^(s-1), then arithmetic-shift right by s. If s <= 0: shift left by -s. Saturate to [-2^(OSZ-1), 2^(OSZ-1)-1]. Any clipping sets sat_flag. Trim is registered: +1 cycle.
- Mux: the cycle after trim, fir_out_valid=1 with I; the next cycle fir_out_valid=1 with Q. R>=2 guarantees no collision. fir_out_data holds its last value when fir_out_valid=0.
- Demux: a parity bit toggles on each fir_in_valid. Even parity stores the word as I; odd parity forms the pair and writes it to the FIFO at that edge.
- FIFO: out_valid = not empty; out_i/out_q show the head. A pop occurs on out_valid && out_ready.
  - Write when full without a pop: the pair is dropped and ovf_flag is set.
  - Write when full with a simultaneous pop: the pair is accepted.
  - Write when empty: out_valid rises the cycle after the write edge (no bypass).
- Flags: clear_flags zeroes both flags at the next edge. A set event in the same cycle wins, so the flag stays 1.
- Reset mid-operation: all state returns to reset values in 1 cycle. FIR words arriving later are taken as a new I/Q sequence starting at even parity.

Test Plan:
- Default parameters, d=2, gain=0, in_valid always 1, in_i=1000, in_q=-500, FIR loopback (fir_in = fir_out delayed 1 cycle) -> after warm-up every pair is out_i=1000, out_q=-500; sat_flag=0.
- Latency: single strobe after warm-up -> fir_out_valid (I) exactly N+2 cycles after the strobe edge, Q at N+3.
- in_i=20000, gain=1, d=2 -> out_i=32767 and sat_flag=1. Pulse clear_flags with the input at 1000 -> flag 0 and stays 0.
- out_ready=0, produce 5 pairs with FIFO_DEPTH=4 -> 4 pairs held, ovf_flag=1. Then out_ready=1 -> the first 4 pairs drain in order, out_valid falls.
- Change dec_log2 2->3 mid-stream -> next N CIC results suppressed, then DC 1000 reproduced at R=8; FIFO contents from before the change intact.
- dec_log2=0 -> behaves as R=2 (one strobe every 2 valid samples); in_valid duty 50% -> strobe every 4 cycles; assert reset mid-pair -> all outputs 0 the next cycle.
